// File: rtl/small_ram_copy_dma.sv
// Single-channel RAM-to-RAM byte copier that drives a synchronous single-port RAM.
// Each byte takes three cycles: read, wait for the read data, then write.
module small_ram_copy_dma #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   src_ptr, dst_ptr;
    logic [ADDR_W:0]     cnt, cnt_dec;
    logic [DATA_W-1:0]   data_r;
    logic                cs_nxt, wr_nxt;
    logic [ADDR_W-1:0]   addr_nxt;

    // Requests longer than the RAM are clamped to one full pass.
    function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    assign cnt_dec = cnt - (ADDR_W+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (sat_len(len) != '0) ? RD : DONE;
            RD:      state_nxt = RWAIT;
            RWAIT:   state_nxt = WR;
            WR:      state_nxt = (cnt_dec != '0) ? RD : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The RAM strobes are registered from the next state so they line up
    // with the state they belong to; the read address of the next byte is
    // looked ahead because the pointers advance on the same edge.
    always_comb begin
        cs_nxt   = 1'b0;
        wr_nxt   = 1'b0;
        addr_nxt = ram_addr;
        case (state_nxt)
            RD: begin
                cs_nxt   = 1'b1;
                addr_nxt = (state == IDLE) ? src_addr : src_ptr + ADDR_W'(1);
            end
            WR: begin
                cs_nxt   = 1'b1;
                wr_nxt   = 1'b1;
                addr_nxt = dst_ptr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            cnt     <= '0;
            data_r  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_ptr <= src_addr;
                    dst_ptr <= dst_addr;
                    cnt     <= sat_len(len);
                end
                RWAIT: data_r <= ram_do;
                WR: begin
                    src_ptr <= src_ptr + ADDR_W'(1);
                    dst_ptr <= dst_ptr + ADDR_W'(1);
                    cnt     <= cnt_dec;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_cs   <= 1'b0;
            ram_wr   <= 1'b0;
            ram_addr <= '0;
        end else begin
            ram_cs   <= cs_nxt;
            ram_wr   <= wr_nxt;
            ram_addr <= addr_nxt;
        end
    end

    // The data register only changes on entry to WR, so it doubles as the
    // write-data output and holds its value between writes.
    assign ram_di = data_r;
    assign busy   = (state == RD) || (state == RWAIT) || (state == WR);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_small_ram_copy_dma.sv
// Randomized scoreboard bench for small_ram_copy_dma with a behavioural RAM
// and a byte-by-byte forward-copy reference model.
module tb_small_ram_copy_dma;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, ram_cs, ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_di;
    logic [DATA_W-1:0] ram_do = '0;

    small_ram_copy_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .busy(busy), .done(done),
        .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    // Synchronous RAM plus a back door for preloading while the DUT is idle.
    logic [DATA_W-1:0] mem [64];
    logic [DATA_W-1:0] ref_mem [64];
    logic              poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_a = '0;
    logic [DATA_W-1:0] poke_v = '0;

    always @(posedge clk) begin
        if (poke_en)                mem[poke_a] <= poke_v;
        else if (ram_cs && ram_wr)  mem[ram_addr] <= ram_di;
        else if (ram_cs)            ram_do <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int start_cyc = 0;
    int done_seen = 0;

    logic [ADDR_W+DATA_W-1:0] wq[$];
    logic [ADDR_W-1:0]        rq[$];
    int                       lat_q[$];
    int                       busy_q[$];

    // Monitor: pops expected traffic whenever the DUT presents a RAM access or done.
    int   busy_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (ram_cs) begin
                checks++;
                if (!busy) begin
                    errors++;
                    $display("FAIL cs_without_busy: cs=%0b busy=%0b required busy=1", ram_cs, busy);
                end
            end
            if (ram_cs && ram_wr) begin
                logic [ADDR_W+DATA_W-1:0] e;
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%h required no write", ram_addr, ram_di);
                end else begin
                    e = wq.pop_front();
                    if ({ram_addr, ram_di} !== e) begin
                        errors++;
                        $display("FAIL write: addr=%0d data=%h required addr=%0d data=%h",
                                 ram_addr, ram_di, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
                    end
                end
            end
            if (ram_cs && !ram_wr) begin
                logic [ADDR_W-1:0] ea;
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: addr=%0d required no read", ram_addr);
                end else begin
                    ea = rq.pop_front();
                    if (ram_addr !== ea) begin
                        errors++;
                        $display("FAIL read_addr: addr=%0d required %0d", ram_addr, ea);
                    end
                end
            end
            if (done) begin
                int el, eb, al;
                checks += 3;
                al = cyc - start_cyc + 1;
                if (prev_done || ram_cs) begin
                    errors++;
                    $display("FAIL done_pulse: prev_done=%0b cs=%0b required 0 0", prev_done, ram_cs);
                end
                if (lat_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: latency=%0d required no done", al);
                end else begin
                    el = lat_q.pop_front();
                    eb = busy_q.pop_front();
                    if (al != el) begin
                        errors++;
                        $display("FAIL latency: got=%0d required=%0d", al, el);
                    end
                    if (busy_cnt != eb) begin
                        errors++;
                        $display("FAIL busy_cycles: got=%0d required=%0d", busy_cnt, eb);
                    end
                end
                done_seen++;
                busy_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_a = a; poke_v = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Reference model: forward byte copy with modulo-64 pointers. keep<0 means
    // the copy completes; otherwise only `keep` bytes finish before an abort.
    task automatic start_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                              input logic [ADDR_W:0] l, input int keep);
        int n, nb;
        logic [ADDR_W-1:0] ra, da;
        n  = (l > 64) ? 64 : int'(l);
        nb = (keep < 0) ? n : keep;
        for (int i = 0; i < nb; i++) begin
            ra = s + ADDR_W'(i);
            da = d + ADDR_W'(i);
            rq.push_back(ra);
            ref_mem[da] = ref_mem[ra];
            wq.push_back({da, ref_mem[ra]});
        end
        if (keep < 0) begin
            lat_q.push_back(3 * n + 1);
            busy_q.push_back(3 * n);
        end else begin
            rq.push_back(s + ADDR_W'(keep));
        end
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0, k;
        n0 = done_seen;
        k  = 0;
        while (done_seen == n0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_seen == n0) begin
            errors++;
            $display("FAIL done_timeout: waited=%0d cycles required done", k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_mem(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        checks++;
        if (mem[a] !== v) begin
            errors++;
            $display("FAIL mem[%0d]: got=%h required=%h", a, mem[a], v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({busy, done, ram_cs, ram_wr} !== 4'b0 || ram_addr !== '0 || ram_di !== '0) begin
            errors++;
            $display("FAIL %s: busy=%0b done=%0b cs=%0b wr=%0b addr=%0d di=%h required all 0",
                     tag, busy, done, ram_cs, ram_wr, ram_addr, ram_di);
        end
    endtask

    initial begin
        int k, nrd;
        #1;
        check_reset_outputs("reset_state");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        rst = 1'b0;

        for (int i = 0; i < 64; i++) poke(ADDR_W'(i), DATA_W'($urandom));

        // Basic copy
        poke(6'd4, 8'hA1); poke(6'd5, 8'hB2); poke(6'd6, 8'hC3);
        start_copy(6'd4, 6'd20, 7'd3, -1);
        wait_done(100);
        check_mem(6'd20, 8'hA1); check_mem(6'd21, 8'hB2); check_mem(6'd22, 8'hC3);

        // Zero length
        start_copy(6'd9, 6'd30, 7'd0, -1);
        wait_done(20);

        // Wrap across address 63 -> 0
        poke(6'd62, 8'h11); poke(6'd63, 8'h22); poke(6'd0, 8'h33);
        start_copy(6'd62, 6'd10, 7'd3, -1);
        wait_done(100);
        check_mem(6'd10, 8'h11); check_mem(6'd11, 8'h22); check_mem(6'd12, 8'h33);

        // Overlapping forward copy replicates the first byte
        poke(6'd5, 8'h5A);
        start_copy(6'd5, 6'd6, 7'd4, -1);
        wait_done(100);
        for (int i = 6; i <= 9; i++) check_mem(ADDR_W'(i), 8'h5A);

        // Oversized length clamps to 64 bytes
        start_copy(6'd40, 6'd3, 7'd100, -1);
        wait_done(400);

        // A start pulse during WR is dropped
        start_copy(6'd16, 6'd48, 7'd6, -1);
        k = 0;
        while (!(ram_cs && ram_wr) && k < 50) begin
            @(negedge clk);
            k++;
        end
        src_addr = ADDR_W'($urandom); dst_addr = ADDR_W'($urandom);
        len = 7'd64; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(100);
        repeat (5) @(negedge clk);

        // Reset in RWAIT of the second byte of a 5-byte copy
        start_copy(6'd24, 6'd56, 7'd5, 1);
        nrd = 0; k = 0;
        while (nrd < 2 && k < 50) begin
            @(negedge clk);
            if (ram_cs && !ram_wr) nrd++;
            k++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset_mid_copy");
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_mid_copy_held");
        rst = 1'b0;

        // Randomized copies
        for (int t = 0; t < 10; t++) begin
            logic [ADDR_W-1:0] s, d;
            logic [ADDR_W:0]   l;
            s = ADDR_W'($urandom);
            d = ADDR_W'($urandom);
            l = (t % 4 == 0) ? (ADDR_W+1)'($urandom_range(65, 127))
                             : (ADDR_W+1)'($urandom_range(0, 20));
            start_copy(s, d, l, -1);
            wait_done(400);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (wq.size() != 0 || rq.size() != 0 || lat_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: writes=%0d reads=%0d dones=%0d required 0 0 0",
                     wq.size(), rq.size(), lat_q.size());
        end
        for (int i = 0; i < 64; i++) check_mem(ADDR_W'(i), ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
